lock_arbiter: RTL and testbench
===============================

# lock_arbiter

Sequential round-robin arbiter that turns a level-sensitive request vector into a registered, locked grant and holds ownership until the owner releases it, drops its request, or times out. It sits directly downstream of the request-collection logic and upstream of the shared resource's data multiplexer. It contains a pointer-masked two-pass priority encode, with lowest index first inside each pass. O_GrtNo drives mux selects; O_Grt drives per-requester acknowledges.

## Interface
- NUM_ENTRY, 20, number of requesters (≥2)
- TIMEOUT, 0, maximum lock duration in cycles; 0 disables the timeout
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- I_Req  in  NUM_ENTRY  level request per requester
- I_Rls  in  1  release strobe from current owner; ignored when not locked
- O_Grt  out  NUM_ENTRY  registered one-hot grant; all-zero when unlocked
- O_GrtNo  out  $clog2(NUM_ENTRY)  registered index of owner; 0 when unlocked
- O_Vld  out  1  registered lock-valid (== |O_Grt)
- O_Tmo  out  1  one-cycle pulse on forced timeout release

## Operation
- Reset values: state IDLE, O_Grt 0, O_GrtNo 0, O_Vld 0, O_Tmo 0, pointer Ptr 0, timeout counter Cnt 0.
- States: IDLE and LOCK.
- IDLE:
  - If I_Req == 0: stay in IDLE.
  - Else select a winner, register O_Grt/O_GrtNo/O_Vld, clear Cnt, go to LOCK.
- Winner selection (combinational, evaluated in IDLE only):
  - Pass 1: lowest set index k of I_Req masked to indices ≥ Ptr.
  - Pass 2, only if pass 1 is empty: lowest set index of the unmasked I_Req.
- Ptr update on every new grant to k: Ptr = k+1, wrapping to 0 when k = NUM_ENTRY-1.
- LOCK exits to IDLE at the next edge on any of the following, with O_Grt/O_GrtNo/O_Vld cleared:
  - (a) I_Rls = 1.
  - (b) I_Req[O_GrtNo] = 0 (owner withdrew).
  - (c) TIMEOUT ≠ 0 and Cnt == TIMEOUT-1. O_Tmo pulses 1 for exactly this transition cycle, and only when neither (a) nor (b) also holds.
- In LOCK with no exit condition, Cnt increments (saturating at TIMEOUT-1). O_Grt is stable; new or changed requests from non-owners are ignored.
- Simultaneous exit conditions: one exit occurs; O_Tmo = 0 when (a) or (b) is present.
- No back-to-back re-grant: at least one IDLE cycle separates consecutive locks. This is intentional; it gives the downstream mux a clean deselect cycle.
- reset has priority over every condition, including an in-progress lock. The next grant after reset starts from Ptr 0.
- Cnt width: $clog2(TIMEOUT+1); the counter is omitted when TIMEOUT = 0.

## Timing
- Request latency: I_Req nonzero sampled in IDLE at edge t; O_Grt/O_Vld valid after edge t (visible cycle t+1).
- Release latency: exit condition sampled at edge t; O_Vld low after edge t. Earliest next grant is visible after edge t+1.
- Timeout: grant visible after edge t; with no release, the forced release takes effect at edge t+TIMEOUT. O_Tmo is high during the cycle following that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle (NUM_ENTRY=4): after reset, I_Req=0000 for 5 cycles. Required: O_Vld=0, O_Grt=0000, O_GrtNo=0 throughout.
- Basic lock/release: I_Req=0110 from reset, I_Rls pulsed 3 cycles after grant. Required:
  - O_Grt=0010, O_GrtNo=1 one cycle after the request.
  - The grant holds despite I_Req[2].
  - O_Vld=0 one cycle after I_Rls.
  - O_Grt=0100, O_GrtNo=2 the cycle after that.
- Round-robin wrap: I_Req=1001 held, owner releases immediately each time. Required: grant sequence 0, 3, 0, 3 with one idle cycle between each; Ptr wraps 3→0.
- Owner withdraw: grant to 2 (I_Req=0100); I_Req drops to 0001 with no I_Rls. Required: O_Vld=0 next cycle, then O_Grt=0001; O_Tmo stays 0.
- Timeout (TIMEOUT=4): I_Req=0001 held, no I_Rls. Required:
  - O_Vld high for exactly 4 cycles.
  - O_Tmo=1 for one cycle as O_Vld falls.
  - Re-grant to 0 after one idle cycle.
  - Repeating I_Rls together with the final timeout cycle gives O_Tmo=0.
- Reset mid-lock: assert reset while O_Grt=1000. Required: all outputs 0 on the next cycle; the first grant after reset is I_Req=1010 → index 1 (Ptr back to 0).

Source files
------------

// File: rtl/lock_arbiter.sv
// Round-robin arbiter that locks a registered one-hot grant to one requester
// until it releases, withdraws its request, or (optionally) times out.
module lock_arbiter #(
    parameter int  NUM_ENTRY = 20,
    parameter int  TIMEOUT   = 0,
    localparam int IW        = $clog2(NUM_ENTRY)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_ENTRY-1:0] I_Req,
    input  logic                 I_Rls,
    output logic [NUM_ENTRY-1:0] O_Grt,
    output logic [IW-1:0]        O_GrtNo,
    output logic                 O_Vld,
    output logic                 O_Tmo
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          owner_req;
    logic          tmo_hit;
    logic          lock_exit;

    // Two-pass encode: first pass only sees indices at or above the pointer,
    // second pass (only if the first found nothing) sees the whole vector.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (!win_vld && I_Req[i] && (i >= 32'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (!win_vld && I_Req[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = win_idx + IW'(1);
        if (win_idx == IW'(NUM_ENTRY - 1)) begin
            ptr_d = '0;
        end
    end

    assign owner_req = I_Req[O_GrtNo];
    assign lock_exit = I_Rls || !owner_req || tmo_hit;

    if (TIMEOUT > 0) begin : g_cnt
        localparam int CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        assign tmo_hit = (state_q == LOCK) && (cnt_q == CW'(TIMEOUT - 1));

        always_comb begin
            cnt_d = '0;
            if (state_q == LOCK && !lock_exit) begin
                cnt_d = tmo_hit ? cnt_q : cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end else begin : g_no_cnt
        assign tmo_hit = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            O_Grt   <= '0;
            O_GrtNo <= '0;
            O_Vld   <= 1'b0;
            O_Tmo   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    O_Tmo <= 1'b0;
                    if (win_vld) begin
                        O_Grt   <= NUM_ENTRY'(1) << win_idx;
                        O_GrtNo <= win_idx;
                        O_Vld   <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (lock_exit) begin
                        O_Grt   <= '0;
                        O_GrtNo <= '0;
                        O_Vld   <= 1'b0;
                        // Timeout is only flagged when it is the sole cause.
                        O_Tmo   <= tmo_hit && !I_Rls && owner_req;
                        state_q <= IDLE;
                    end else begin
                        O_Tmo <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_arbiter.sv
// Table-driven bench for lock_arbiter (4 requesters, timeout of 4 cycles)
// with a scoreboard queue of expected registered outputs.
module tb_lock_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] I_Req;
    logic       I_Rls;
    logic [3:0] O_Grt;
    logic [1:0] O_GrtNo;
    logic       O_Vld;
    logic       O_Tmo;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rls;
        logic [3:0] grt;
        logic [1:0] no;
        logic       vld;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic [3:0] grt;
        logic [1:0] no;
        logic       vld;
        logic       tmo;
        string      tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[25];

    lock_arbiter #(.NUM_ENTRY(4), .TIMEOUT(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .I_Req  (I_Req),
        .I_Rls  (I_Rls),
        .O_Grt  (O_Grt),
        .O_GrtNo(O_GrtNo),
        .O_Vld  (O_Vld),
        .O_Tmo  (O_Tmo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic rls,
                                input logic [3:0] grt, input logic [1:0] no,
                                input logic vld, input logic tmo);
        vec_t v;
        v.rst = rst; v.req = req; v.rls = rls;
        v.grt = grt; v.no = no; v.vld = vld; v.tmo = tmo;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: output cycle with no expected entry");
        end else begin
            e = sb.pop_front();
            if (O_Grt !== e.grt || O_GrtNo !== e.no || O_Vld !== e.vld || O_Tmo !== e.tmo) begin
                miscompares++;
                $display("FAIL %s: got grt=%b no=%0d vld=%b tmo=%b, want grt=%b no=%0d vld=%b tmo=%b",
                         e.tag, O_Grt, O_GrtNo, O_Vld, O_Tmo, e.grt, e.no, e.vld, e.tmo);
            end
        end
    endtask

    // Drive one cycle of inputs; expected values are the outputs after the
    // next rising edge.
    task automatic step(input logic rst, input logic [3:0] req, input logic rls,
                        input logic [3:0] grt, input logic [1:0] no,
                        input logic vld, input logic tmo, input string tag);
        exp_t e;
        reset = rst;
        I_Req = req;
        I_Rls = rls;
        e.grt = grt; e.no = no; e.vld = vld; e.tmo = tmo; e.tag = tag;
        sb.push_back(e);
        vectors_applied++;
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        reset = 1'b1;
        I_Req = '0;
        I_Rls = 1'b0;

        // reset, then idle
        tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // basic lock/release, grant to 1 held despite req[2], then 2
        tbl[6]  = mk(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // round-robin wrap from reset: 0, 3, 0, 3
        tbl[12] = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // owner withdraw: 2 drops, then second pass picks 0 (ptr=3)
        tbl[21] = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        tbl[22] = mk(1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tbl[23] = mk(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        tbl[24] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rls, tbl[i].grt, tbl[i].no,
                 tbl[i].vld, tbl[i].tmo, $sformatf("vec%0d", i));
        end

        // timeout: 4 locked cycles, forced release with O_Tmo, regrant after one idle
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "tmo_grant");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("tmo_hold%0d", i));
        end
        step(1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "tmo_pulse");
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "tmo_regrant");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("tmo2_hold%0d", i));
        end
        step(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "tmo_with_rls");

        // reset mid-lock: owner 3, reset, then first grant from Ptr 0
        step(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rst_lock3");
        step(1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_midlock");
        step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_regrant1");
        step(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_release");

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
